// File: rtl/interrupt_controller_if.sv
// Signal bundle between the core (master) and the interrupt controller (slave):
// request lines, context for the stack pushes, push handshake and fetch control.
interface interrupt_controller_if #(
  parameter int unsigned N_IRQ  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 32
);
  logic [N_IRQ-1:0]  irq;
  logic [N_IRQ-1:0]  irq_mask;
  logic [PC_W-1:0]   pc_resume;
  logic [2:0]        flags_in;
  logic              rti;
  logic              push_ready;
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              stall_fetch;
  logic              flush_fetch;
  logic              pc_load;
  logic [PC_W-1:0]   pc_load_value;
  logic [N_IRQ-1:0]  ack;
  logic              busy;

  modport master (
    output irq, irq_mask, pc_resume, flags_in, rti, push_ready,
    input  push_valid, push_data, stall_fetch, flush_fetch, pc_load,
           pc_load_value, ack, busy
  );

  modport slave (
    input  irq, irq_mask, pc_resume, flags_in, rti, push_ready,
    output push_valid, push_data, stall_fetch, flush_fetch, pc_load,
           pc_load_value, ack, busy
  );
endinterface

// File: rtl/interrupt_controller.sv
// Edge-triggered, fixed-priority interrupt controller: drains the pipeline, pushes
// PC (high, low) and flags onto the stack, then loads the vector address and acks.
module interrupt_controller #(
  parameter int unsigned     N_IRQ        = 4,
  parameter int unsigned     DATA_W       = 16,
  parameter int unsigned     PC_W         = 32,
  parameter int unsigned     DRAIN_CYCLES = 3,
  parameter logic [PC_W-1:0] VEC_BASE     = '0,
  parameter int unsigned     VEC_STRIDE   = 2
) (
  input logic                   clk,
  input logic                   rst,
  interrupt_controller_if.slave bus
);
  localparam int unsigned      SEL_W    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_HI,
    S_PUSH_LO,
    S_PUSH_FLG,
    S_VECTOR
  } state_e;

  state_e             state_q, state_d;
  logic [N_IRQ-1:0]   irq_q;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   rise;
  logic [N_IRQ-1:0]   eligible;
  logic               armed_q;
  logic               ie_q, ie_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   winner;
  logic               found;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0]    pc_q;
  logic [2:0]         flg_q;
  logic               leave_idle;
  logic               drain_done;

  logic               push_valid;
  logic [DATA_W-1:0]  push_data;
  logic               stall_fetch;
  logic               flush_fetch;
  logic               pc_load;
  logic [PC_W-1:0]    pc_load_value;
  logic [N_IRQ-1:0]   ack;
  logic               busy;

  // The first edge after reset only primes irq_q, so a line held high through reset
  // needs a fresh low-to-high transition before it counts as a request.
  assign rise       = armed_q ? (bus.irq & ~irq_q) : '0;
  assign eligible   = ie_q ? (pending_q & bus.irq_mask) : '0;
  assign leave_idle = (state_q == S_IDLE) && (|eligible);
  assign drain_done = (state_q == S_DRAIN) && (cnt_q == '0);
  assign pending_d  = (pending_q & ~ack) | rise;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (eligible[i] && !found) begin
        winner = SEL_W'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_d = leave_idle ? winner : sel_q;
    cnt_d = cnt_q;
    if (leave_idle) begin
      cnt_d = CNT_LOAD;
    end else if ((state_q == S_DRAIN) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    ie_d = ie_q;
    if (leave_idle) begin
      ie_d = 1'b0;
    end else if (bus.rti) begin
      ie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q     <= '0;
      armed_q   <= 1'b0;
      pending_q <= '0;
      ie_q      <= 1'b1;
      sel_q     <= '0;
      cnt_q     <= '0;
      pc_q      <= '0;
      flg_q     <= '0;
    end else begin
      irq_q     <= bus.irq;
      armed_q   <= 1'b1;
      pending_q <= pending_d;
      ie_q      <= ie_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      if (drain_done) begin
        pc_q  <= bus.pc_resume;
        flg_q <= bus.flags_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (|eligible)      state_d = S_DRAIN;
      S_DRAIN:    if (cnt_q == '0)    state_d = S_PUSH_HI;
      S_PUSH_HI:  if (bus.push_ready) state_d = S_PUSH_LO;
      S_PUSH_LO:  if (bus.push_ready) state_d = S_PUSH_FLG;
      S_PUSH_FLG: if (bus.push_ready) state_d = S_VECTOR;
      S_VECTOR:                       state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_valid    = 1'b0;
    push_data     = '0;
    stall_fetch   = 1'b0;
    flush_fetch   = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = '0;
    ack           = '0;
    busy          = (state_q != S_IDLE);
    stall_fetch   = (state_q != S_IDLE);
    unique case (state_q)
      S_DRAIN: begin
        flush_fetch = (cnt_q == CNT_LOAD);
      end
      S_PUSH_HI: begin
        push_valid = 1'b1;
        push_data  = pc_q[PC_W-1:DATA_W];
      end
      S_PUSH_LO: begin
        push_valid = 1'b1;
        push_data  = pc_q[DATA_W-1:0];
      end
      S_PUSH_FLG: begin
        push_valid = 1'b1;
        push_data  = DATA_W'(flg_q);
      end
      S_VECTOR: begin
        pc_load       = 1'b1;
        pc_load_value = VEC_BASE + (PC_W'(sel_q) * PC_W'(VEC_STRIDE));
        for (int unsigned i = 0; i < N_IRQ; i++) begin
          ack[i] = (sel_q == SEL_W'(i));
        end
      end
      default: ;
    endcase
  end

  assign bus.push_valid    = push_valid;
  assign bus.push_data     = push_data;
  assign bus.stall_fetch   = stall_fetch;
  assign bus.flush_fetch   = flush_fetch;
  assign bus.pc_load       = pc_load;
  assign bus.pc_load_value = pc_load_value;
  assign bus.ack           = ack;
  assign bus.busy          = busy;
endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter N_IRQ, default 4: number of interrupt request lines, legal range 1..16.
REQ-002 Parameter DATA_W, default 16: stack word width.
REQ-003 Parameter PC_W, default 32: PC width; PC_W SHALL equal 2*DATA_W.
REQ-004 Parameter DRAIN_CYCLES, default 3: cycles the pipeline is drained before the first push, legal range 1..15.
REQ-005 Parameter VEC_BASE, default 0: PC_W-bit address of vector 0.
REQ-006 Parameter VEC_STRIDE, default 2: address distance between consecutive vectors.
REQ-007 One clock; reset is asynchronous and active-high; ports are clk and rst.
REQ-008 Port list (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- irq  in  N_IRQ  level requests, rising-edge sensitive.
- irq_mask  in  N_IRQ  1 = line enabled.
- pc_resume  in  PC_W  PC of the oldest unretired instruction.
- flags_in  in  3  current flag register value.
- rti  in  1  one-cycle pulse: return-from-interrupt retired.
- push_ready  in  1  stack port accepts the word this cycle.
- push_valid  out  1  stack word valid.
- push_data  out  DATA_W  stack word.
- stall_fetch  out  1  freeze PC and the fetch register.
- flush_fetch  out  1  clear the fetched instruction.
- pc_load  out  1  one-cycle PC overwrite strobe.
- pc_load_value  out  PC_W  vector address.
- ack  out  N_IRQ  one-hot, one-cycle service acknowledge.
- busy  out  1  controller not in IDLE.

Function
REQ-009 irq_q SHALL register irq; pending[i] SHALL set at the edge where irq[i]=1 and irq_q[i]=0, and SHALL clear only at the edge where ack[i]=1.
REQ-010 A rising edge coinciding with that line's ack SHALL leave pending[i] set.
REQ-011 Internal ie SHALL be 1 out of reset, SHALL clear on the IDLE->DRAIN transition, and SHALL set on an rti pulse.
REQ-012 eligible = pending & irq_mask, gated by ie; the winner SHALL be the lowest set index, latched into sel_q on leaving IDLE.
REQ-013 FSM states SHALL be IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FLG and VECTOR.
REQ-014 IDLE->DRAIN SHALL occur when eligible is nonzero.
REQ-015 DRAIN: stall_fetch SHALL be 1. flush_fetch SHALL be 1 in the first DRAIN cycle only. A down-counter loaded with DRAIN_CYCLES-1 SHALL move the FSM to PUSH_HI after exactly DRAIN_CYCLES cycles.
REQ-016 PUSH_HI and PUSH_LO: push_data SHALL be pc_resume[PC_W-1:DATA_W] and pc_resume[DATA_W-1:0] respectively, both sampled into a register on DRAIN exit.
REQ-017 PUSH_FLG: push_data SHALL be {zeros, flags_in}, flags_in sampled on DRAIN exit.
REQ-018 Push handshake: push_valid=1 in every PUSH_* state. push_data SHALL be stable while push_ready=0. The FSM SHALL advance only on a cycle with push_valid & push_ready. Each push state consumes at least one cycle.
REQ-019 VECTOR lasts one cycle with pc_load=1, pc_load_value = VEC_BASE + sel_q*VEC_STRIDE (PC_W-bit, wrap modulo 2^PC_W), and ack=1<<sel_q. The next state SHALL be IDLE.
REQ-020 stall_fetch SHALL be 1 in all non-IDLE states; busy SHALL be 1 in all non-IDLE states.
REQ-021 A request arriving while busy or while ie=0 SHALL stay pending and SHALL be serviced after return to IDLE with ie=1.
REQ-022 Changes to irq_mask after the winner is latched SHALL NOT abort or change the service in progress.
REQ-023 An rti pulse while busy SHALL set ie but SHALL NOT alter the FSM.
REQ-024 Outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from irq to any output.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, pending=0, irq_q=0, ie=1, counter=0, and all outputs to 0, including mid-service.
REQ-026 After rst deasserts, an irq line already high SHALL NOT register as an edge until it falls and rises again.

Verification
REQ-027 Single request, default parameters: irq[2] rises with push_ready=1 -> DRAIN 3 cycles, then pushes pc_resume 0x0001_0040 as 0x0001 then 0x0040, then flags 0x0005. Next cycle: pc_load=1, pc_load_value=0x0000_0004, ack=0b0100. The sequence lasts 7 cycles after IDLE exit.
REQ-028 Priority: irq[3] and irq[1] rise on the same edge -> line 1 is serviced first (vector 0x2). After rti, line 3 is serviced (vector 0x6).
REQ-029 Backpressure: push_ready=0 for 4 cycles during PUSH_LO -> push_valid held, push_data held at 0x0040, no state advance, and total sequence length grows by 4.
REQ-030 Mask and ie: irq[0] rises with irq_mask[0]=0 -> pending but no service. Setting the mask bit later starts service. A second irq during service waits until rti.
REQ-031 rst asserted in PUSH_HI -> next sample shows busy=0, push_valid=0, stall_fetch=0, pending=0. After release, no service occurs while irq stays high.
